piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready handshake and
//  drives it LSB-first, one bit per clk, on sdr. Sits directly upstream of the serial-in right
//  shift register and feeds its SDR input. After WIDTH shifts, that register holds the word unchanged.
// PARAMETERS
//  WIDTH       4   data bits per word (>=2)
//  IDLE_LEVEL  0   value driven on sdr when no bit is being sent
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  clrb       in   1      asynchronous, active-low reset
//  din        in   WIDTH  parallel word to send
//  din_valid  in   1      din holds a word to send
//  din_ready  out  1      serializer can accept din on this edge
//  sdr        out  1      serial data out; connects to the receiver's SDR input
//  sdr_valid  out  1      sdr carries a frame bit this cycle
//  busy       out  1      a word is being shifted out
//  done       out  1      1-cycle pulse: the last bit of the frame is on sdr this cycle
// BEHAVIOUR
//  - Reset (clrb=0, async): state=IDLE, shift reg=0, bit count=0, sdr=IDLE_LEVEL,
//    sdr_valid=0, busy=0, done=0. din_ready is forced to 0 while clrb=0.
//  - Outputs sdr, sdr_valid, busy and done are registered. din_ready is decoded from state.
//  - Accept: a word is taken on a posedge where din_valid && din_ready. din is sampled at that edge.
//  - FSM IDLE -> SHIFT on accept.
//    - SHIFT: cycle k (k=0..WIDTH-1) drives sdr=word[k], sdr_valid=1, busy=1.
//    - The first bit appears on the cycle after accept.
//  - Latency: accept edge + 1 cycle = first bit; the frame occupies WIDTH consecutive cycles.
//  - din_ready = (state==IDLE) || (final bit of the frame is on sdr).
//    - Accepting during the final bit starts the next frame with zero bubble.
//    - Otherwise the FSM returns to IDLE: sdr=IDLE_LEVEL, sdr_valid=0, busy=0.
//  - done=1 exactly in the cycle the final frame bit is driven, and in no other cycle.
//  - din_valid while busy and not in the final cycle is ignored: din_ready=0, no state change.
//  - Bit counter: $clog2(WIDTH+1) bits. It counts 0..last and never wraps mid-frame.
//  - Reset mid-frame aborts immediately; the partial frame is dropped and not resumed.
//  - din_valid during reset is ignored. The first accept can happen on the first posedge with clrb=1.
// CONFIGURATION
//  - SERIAL_PARITY_EN defined: one extra cycle after the data bits drives the even-parity bit
//    (^word) with sdr_valid=1. Frame = WIDTH+1 cycles; done and the early din_ready move to the parity cycle.
//  - SERIAL_PARITY_EN undefined: frame = WIDTH cycles; no parity logic.
// STRUCTURE
//  - Shared package serializer_pkg holds:
//    - typedef enum {IDLE, SHIFT, PARITY} ser_state_t
//    - localparam FRAME_LEN(WIDTH), a function for the counter width
//    - function even_parity()
//  - One sub-module: ser_bit_counter (load/clear, increment, last-bit flag).
//  - The FSM, shift register and output registers stay in the top module.
// TESTING
//  1. Reset: hold clrb=0 with din_valid=1.
//     -> sdr=0, sdr_valid=0, busy=0, done=0, din_ready=0; nothing is sent after release.
//  2. Single word: accept din=4'b1011.
//     -> sdr=1,1,0,1 on the next 4 cycles, done on the 4th.
//     -> A downstream right shift register then holds Q=4'b1011.
//  3. Back-to-back: din=4'hA, then din=4'h5 held valid.
//     -> 8 contiguous valid bits 0,1,0,1,1,0,1,0; done pulses on cycles 4 and 8.
//  4. Ignored input: change din to 4'hF in frame cycle 1.
//     -> The frame still outputs the original word; din_ready=0 until the final cycle.
//  5. Abort: pulse clrb low during frame cycle 2.
//     -> Outputs return to reset values asynchronously; the next accepted word is sent intact.
//  6. SERIAL_PARITY_EN defined: din=4'b0111.
//     -> sdr=1,1,1,0, then parity 1; done on the 5th cycle.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// serializer_pkg: shared types and helpers for the PISO serializer.
//   ser_state_t  : FSM states (IDLE, SHIFT, PARITY)
//   cnt_width()  : bit-counter width for a given word width
//   frame_len()  : cycles per frame (WIDTH, or WIDTH+1 with SERIAL_PARITY_EN)
//   even_parity(): XOR reduction of a word (words up to 32 bits)
// Optional feature macro: SERIAL_PARITY_EN (appends an even-parity bit).
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  // Counter must be able to hold WIDTH itself (the parity slot index).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int frame_len(input int width);
`ifdef SERIAL_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake and serial output bundle.
//   din, din_valid : parallel word offered by the source
//   din_ready      : serializer accepts din on this edge
//   sdr, sdr_valid : serial bit and its frame-bit qualifier
//   busy, done     : frame in progress / final frame bit on sdr
// Modports: master = word source / serial sink side, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sdr;
  logic             sdr_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, sdr, sdr_valid, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sdr, sdr_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// ser_bit_counter: frame bit index counter.
//   clk, clrb : clock, asynchronous active-low reset
//   clr       : restart at 0 (new frame accepted); wins over inc
//   inc       : advance to the next bit
//   last      : index == LAST (final frame bit on sdr)
//   penult    : index == LAST-1 (next bit is the final one)
module ser_bit_counter #(
  parameter int CW   = 3,
  parameter int LAST = 3
) (
  input  logic clk,
  input  logic clrb,
  input  logic clr,
  input  logic inc,
  output logic last,
  output logic penult
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last   = (cnt == CW'(LAST));
  assign penult = (cnt == CW'(LAST - 1));
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter, LSB first.
//   clk  : clock, all state changes on posedge
//   clrb : asynchronous active-low reset
//   bus  : piso_serializer_if.slave (din/din_valid/din_ready handshake,
//          registered sdr/sdr_valid/busy/done outputs)
// Parameters: WIDTH (bits per word, >=2, <=32), IDLE_LEVEL (sdr when idle).
// Optional feature macro: SERIAL_PARITY_EN adds an even-parity bit after
// the data bits; done and the early din_ready then move to that cycle.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   clrb,
  piso_serializer_if.slave       bus
);
  localparam int CW        = cnt_width(WIDTH);
  localparam int FRAME_LEN = frame_len(WIDTH);

  ser_state_t       state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic             sdr_q, sdr_nx;
  logic             vld_q, vld_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             cnt_clr, cnt_inc, cnt_last, cnt_penult;
  logic             ready, accept;
`ifdef SERIAL_PARITY_EN
  logic             par, par_nx;
`endif

  // Counter index tracks the bit currently on sdr, across the whole frame
  // (parity slot included), so last marks the final frame bit in both builds.
  ser_bit_counter #(
    .CW   (CW),
    .LAST (FRAME_LEN - 1)
  ) u_cnt (
    .clk    (clk),
    .clrb   (clrb),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .last   (cnt_last),
    .penult (cnt_penult)
  );

  // Ready while idle or while the final bit is out, so a new word can
  // follow with no bubble. Held low during reset.
  assign ready  = clrb && ((state == IDLE) || ((state != IDLE) && cnt_last));
  assign accept = bus.din_valid && ready;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    sdr_nx   = IDLE_LEVEL;
    vld_nx   = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_nx   = par;
`endif
    if (accept) begin
      // Bit 0 goes straight to the output register; shreg keeps the rest.
      state_nx = SHIFT;
      shreg_nx = bus.din >> 1;
      sdr_nx   = bus.din[0];
      vld_nx   = 1'b1;
      busy_nx  = 1'b1;
      cnt_clr  = 1'b1;
`ifdef SERIAL_PARITY_EN
      par_nx   = even_parity(32'(bus.din));
`endif
    end else begin
      case (state)
        SHIFT: begin
`ifdef SERIAL_PARITY_EN
          // penult here means the last data bit is out; parity follows.
          if (cnt_penult) begin
            state_nx = PARITY;
            sdr_nx   = par;
          end else begin
            sdr_nx   = shreg[0];
            shreg_nx = shreg >> 1;
          end
          vld_nx  = 1'b1;
          busy_nx = 1'b1;
          cnt_inc = 1'b1;
          done_nx = cnt_penult;
`else
          if (!cnt_last) begin
            sdr_nx   = shreg[0];
            shreg_nx = shreg >> 1;
            vld_nx   = 1'b1;
            busy_nx  = 1'b1;
            cnt_inc  = 1'b1;
            done_nx  = cnt_penult;
          end else begin
            state_nx = IDLE;
          end
`endif
        end
        PARITY:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state  <= IDLE;
      shreg  <= '0;
      sdr_q  <= IDLE_LEVEL;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      sdr_q  <= sdr_nx;
      vld_q  <= vld_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
`ifdef SERIAL_PARITY_EN
      par    <= par_nx;
`endif
    end
  end

  assign bus.din_ready = ready;
  assign bus.sdr       = sdr_q;
  assign bus.sdr_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer (WIDTH=4).
// Builds with or without SERIAL_PARITY_EN; expected frames include the
// parity bit when the macro is defined.
module tb_piso_serializer;
`ifdef SERIAL_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic clk = 1'b0;
  logic clrb;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] rx_q = 4'h0;

  piso_serializer_if #(.WIDTH(4)) bus ();

  piso_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut (
    .clk  (clk),
    .clrb (clrb),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Downstream serial-in right shift register fed from sdr.
  always @(posedge clk) begin
    if (bus.sdr_valid) rx_q <= {bus.sdr, rx_q[3:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [3:0] w, input int k);
    if (k < 4) return w[k];
    return ^w;
  endfunction

  task automatic check_bit(input string tag, input logic b, input logic last);
    check({tag, ".sdr"},       bus.sdr,       b);
    check({tag, ".sdr_valid"}, bus.sdr_valid, 1'b1);
    check({tag, ".busy"},      bus.busy,      1'b1);
    check({tag, ".done"},      bus.done,      last);
    check({tag, ".din_ready"}, bus.din_ready, last);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sdr"},       bus.sdr,       1'b0);
    check({tag, ".sdr_valid"}, bus.sdr_valid, 1'b0);
    check({tag, ".busy"},      bus.busy,      1'b0);
    check({tag, ".done"},      bus.done,      1'b0);
    check({tag, ".din_ready"}, bus.din_ready, 1'b1);
  endtask

  // Offer one word, drop valid after acceptance, check every frame cycle
  // and the idle cycle after it.
  task automatic send(input string tag, input logic [3:0] w);
    bus.din       = w;
    bus.din_valid = 1'b1;
    for (int k = 0; k < FLEN; k++) begin
      tick();
      if (k == 0) bus.din_valid = 1'b0;
      check_bit($sformatf("%s.b%0d", tag, k), exp_bit(w, k), k == FLEN - 1);
    end
    tick();
    check_idle({tag, ".after"});
  endtask

  initial begin
    // Reset held with a valid word pending.
    clrb          = 1'b0;
    bus.din       = 4'hF;
    bus.din_valid = 1'b1;
    #1;
    check("rst.din_ready_async", bus.din_ready, 1'b0);
    tick();
    tick();
    check("rst.sdr",       bus.sdr,       1'b0);
    check("rst.sdr_valid", bus.sdr_valid, 1'b0);
    check("rst.busy",      bus.busy,      1'b0);
    check("rst.done",      bus.done,      1'b0);
    check("rst.din_ready", bus.din_ready, 1'b0);
    bus.din_valid = 1'b0;
    clrb          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("rel.c%0d", i));
    end

    // Single word 1011 -> 1,1,0,1.
    send("single", 4'b1011);
`ifndef SERIAL_PARITY_EN
    check("single.rx_q", rx_q, 4'b1011);
`endif

    // Back-to-back A then 5 with no bubble.
    bus.din       = 4'hA;
    bus.din_valid = 1'b1;
    for (int k = 0; k < FLEN; k++) begin
      tick();
      if (k == 0) bus.din = 4'h5;
      check_bit($sformatf("b2b.a%0d", k), exp_bit(4'hA, k), k == FLEN - 1);
    end
    for (int k = 0; k < FLEN; k++) begin
      tick();
      if (k == 0) bus.din_valid = 1'b0;
      check_bit($sformatf("b2b.5_%0d", k), exp_bit(4'h5, k), k == FLEN - 1);
    end
    tick();
    check_idle("b2b.after");
`ifndef SERIAL_PARITY_EN
    check("b2b.rx_q", rx_q, 4'h5);
`endif

    // din changed to F mid-frame while valid stays high: ignored.
    bus.din       = 4'h6;
    bus.din_valid = 1'b1;
    for (int k = 0; k < FLEN; k++) begin
      tick();
      if (k == 0) bus.din = 4'hF;
      if (k == FLEN - 1) bus.din_valid = 1'b0;
      check_bit($sformatf("ign.b%0d", k), exp_bit(4'h6, k), k == FLEN - 1);
    end
    tick();
    check_idle("ign.after");

    // Abort during frame cycle 2, then send a fresh word intact.
    bus.din       = 4'hC;
    bus.din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) bus.din_valid = 1'b0;
      check_bit($sformatf("abort.b%0d", k), exp_bit(4'hC, k), 1'b0);
    end
    #2;
    clrb = 1'b0;
    #1;
    check("abort.sdr",       bus.sdr,       1'b0);
    check("abort.sdr_valid", bus.sdr_valid, 1'b0);
    check("abort.busy",      bus.busy,      1'b0);
    check("abort.done",      bus.done,      1'b0);
    check("abort.din_ready", bus.din_ready, 1'b0);
    #1;
    clrb = 1'b1;
    tick();
    check_idle("abort.idle");
    send("resume", 4'h9);
`ifndef SERIAL_PARITY_EN
    check("resume.rx_q", rx_q, 4'h9);
`endif

    // 0111 -> 1,1,1,0 (+ parity 1 when enabled).
    send("par", 4'b0111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
